ddr_burst_arbiter: RTL and testbench
====================================

# ddr_burst_arbiter

Burst scheduler between the user-side write/read FIFOs and the AXI DDR3 master. It watches the write-FIFO fill level and the read-FIFO free space, and grants one full burst at a time to either direction under round-robin. It generates the start address of each burst from two independent wrapping pointers over a circular frame region, and it withholds all traffic until MIG calibration completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 30, AXI byte-address width.
- `BURST_LEN`, 64, beats per burst.
- `BYTES_PER_BEAT`, 16, bytes per beat (128-bit data).
- `FIFO_DEPTH`, 512, read-FIFO depth in beats.
- `CNT_WIDTH`, 10, width of FIFO level inputs.
- `WR_BASE`, 0, write region base byte address.
- `RD_BASE`, 0, read region base byte address.
- `REGION_BYTES`, 4096, region size; must be a nonzero multiple of BURST_LEN*BYTES_PER_BEAT.

Ports:
- `clk` in 1: DDR user clock.
- `reset` in 1: asynchronous, active-high.
- `init_calib_complete` in 1: MIG calibration done.
- `wr_fifo_cnt` in CNT_WIDTH: beats available in write FIFO.
- `rd_fifo_cnt` in CNT_WIDTH: beats occupied in read FIFO.
- `rd_enable` in 1: read traffic permitted.
- `wr_addr_clr` in 1: pulse, return write pointer to WR_BASE.
- `rd_addr_clr` in 1: pulse, return read pointer to RD_BASE.
- `wr_burst_req` out 1: write burst request.
- `wr_burst_addr` out ADDR_WIDTH: write burst start address.
- `wr_burst_ack` in 1: master accepted write request.
- `wr_burst_done` in 1: write response received.
- `rd_burst_req` out 1: read burst request.
- `rd_burst_addr` out ADDR_WIDTH: read burst start address.
- `rd_burst_ack` in 1: master accepted read request.
- `rd_burst_done` in 1: last read beat received.
- `wr_wrap` out 1: one-cycle pulse on write-pointer wrap.
- `rd_wrap` out 1: one-cycle pulse on read-pointer wrap.
- `busy` out 1: state other than IDLE.

## Operation
- BURST_BYTES = BURST_LEN*BYTES_PER_BEAT. Pointer arithmetic is done in ADDR_WIDTH+1 bits.
- Eligibility:
  - `wr_ok` = calib && wr_fifo_cnt >= BURST_LEN.
  - `rd_ok` = calib && rd_enable && (FIFO_DEPTH − rd_fifo_cnt) >= BURST_LEN.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- IDLE:
  - Pending clears are applied first: ptr := base, and a pending clear does not raise a wrap pulse.
  - Then arbitration. Only one eligible → grant it. Both eligible → grant the direction not granted last (`last_wr` flag; reset value = read, so write wins the first tie). Neither → stay.
- WR_REQ: `wr_burst_req`=1 with `wr_burst_addr`=wr_ptr held stable. On `wr_burst_ack` → WR_WAIT.
- WR_WAIT: on `wr_burst_done` → IDLE, and wr_ptr := next.
  - next = ptr+BURST_BYTES if that value is < base+REGION_BYTES; otherwise next = base and `wr_wrap` pulses.
  - If a clear is pending, ptr := base instead and no wrap pulse is raised.
- RD_REQ/RD_WAIT: identical to WR_REQ/WR_WAIT using the read-side signals.
- ack and done in the same cycle while in *_REQ: treated as ack followed by done, i.e. go directly to IDLE and advance the pointer.
- done outside *_WAIT or *_REQ is ignored. ack outside *_REQ is ignored.
- `wr_addr_clr`/`rd_addr_clr` set a sticky pending flag, which clears when applied. A clear arriving during a burst is deferred until that burst completes, so the in-flight address never changes.
- Calibration dropping mid-burst does not abort the burst; it only blocks new grants.

## Timing
- All outputs are registered. Reset values: req=0, addr=base, wrap=0, busy=0, state=IDLE, last_wr=0, pending flags=0.
- Eligibility sampled in IDLE at edge N → req=1 and addr valid from edge N+1.
- req deasserts on the edge after ack is sampled.
- done sampled at edge M → state IDLE at M+1, with the updated pointer and any wrap pulse visible for exactly that cycle. The earliest next req is M+2.
- Minimum one IDLE cycle between bursts. Address is stable throughout REQ and WAIT.
- `busy` = (state != IDLE), registered with state.
- Asynchronous reset in any state immediately forces reset values. An outstanding master transaction is abandoned; the master is reset by the same `reset`.

## Test plan
- Calibration gate: `init_calib_complete`=0, wr_fifo_cnt=100 → no req for 50 cycles. Raise calib → `wr_burst_req` one cycle after IDLE samples it, addr=0x0.
- Write sequence and wrap: wr_fifo_cnt=64 held, ack after 3 cycles, done after 10 → addrs 0x000, 0x400, 0x800, 0xC00, 0x000. `wr_wrap` pulses once, coincident with the return to 0x000.
- Round-robin: wr_fifo_cnt=64, rd_fifo_cnt=0, rd_enable=1 → grants alternate W,R,W,R. rd addrs 0x000, 0x400; wr addrs 0x000, 0x400.
- Read back-pressure: rd_fifo_cnt=449 (free 63) → no read grant. rd_fifo_cnt=448 → `rd_burst_req` asserts. rd_enable=0 → no read grant regardless.
- Deferred clear: `wr_addr_clr` pulse during WR_WAIT at addr 0x400 → addr held 0x400 through done, next write addr 0x000, no `wr_wrap`.
- Reset mid-burst: assert reset in RD_WAIT → req=0, busy=0, pointers=base immediately. After release, the first grant on a tie is write.

Source files
------------

// File: rtl/ddr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_burst_arbiter
//
// Schedules full-length bursts between the user-side write/read FIFOs and the
// AXI DDR3 master. One burst is in flight at a time. When both directions are
// eligible they alternate (round-robin). Burst start addresses come from two
// independent pointers that walk a circular region each and wrap back to the
// region base. No traffic is granted until MIG calibration has completed.
//
// Ports:
//   clk, reset             DDR user clock, asynchronous active-high reset
//   init_calib_complete    MIG calibration done (gates new grants only)
//   wr_fifo_cnt            beats available in the write FIFO
//   rd_fifo_cnt            beats occupied in the read FIFO
//   rd_enable              read traffic permitted
//   wr_addr_clr/rd_addr_clr  pulse: return pointer to its base (deferred
//                          while a burst of that direction is in flight)
//   wr_burst_req/addr      write burst request + start address
//   wr_burst_ack/done      master accepted / write response received
//   rd_burst_req/addr      read burst request + start address
//   rd_burst_ack/done      master accepted / last read beat received
//   wr_wrap/rd_wrap        one-cycle pulse when a pointer wraps to base
//   busy                   arbiter is not idle
// ---------------------------------------------------------------------------
module ddr_burst_arbiter #(
   parameter int ADDR_WIDTH     = 30,
   parameter int BURST_LEN      = 64,
   parameter int BYTES_PER_BEAT = 16,
   parameter int FIFO_DEPTH     = 512,   // must be >= BURST_LEN
   parameter int CNT_WIDTH      = 10,
   parameter int WR_BASE        = 0,
   parameter int RD_BASE        = 0,
   parameter int REGION_BYTES   = 4096   // nonzero multiple of a burst
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init_calib_complete,
   input  logic [CNT_WIDTH-1:0]  wr_fifo_cnt,
   input  logic [CNT_WIDTH-1:0]  rd_fifo_cnt,
   input  logic                  rd_enable,
   input  logic                  wr_addr_clr,
   input  logic                  rd_addr_clr,
   output logic                  wr_burst_req,
   output logic [ADDR_WIDTH-1:0] wr_burst_addr,
   input  logic                  wr_burst_ack,
   input  logic                  wr_burst_done,
   output logic                  rd_burst_req,
   output logic [ADDR_WIDTH-1:0] rd_burst_addr,
   input  logic                  rd_burst_ack,
   input  logic                  rd_burst_done,
   output logic                  wr_wrap,
   output logic                  rd_wrap,
   output logic                  busy
);

   localparam int BURST_BYTES = BURST_LEN * BYTES_PER_BEAT;

   // Pointer arithmetic is one bit wider than the address so the
   // end-of-region compare cannot overflow.
   localparam logic [ADDR_WIDTH:0]   C_BURST_BYTES = (ADDR_WIDTH+1)'(BURST_BYTES);
   localparam logic [ADDR_WIDTH:0]   C_WR_END      = (ADDR_WIDTH+1)'(WR_BASE + REGION_BYTES);
   localparam logic [ADDR_WIDTH:0]   C_RD_END      = (ADDR_WIDTH+1)'(RD_BASE + REGION_BYTES);
   localparam logic [ADDR_WIDTH-1:0] C_WR_BASE     = ADDR_WIDTH'(WR_BASE);
   localparam logic [ADDR_WIDTH-1:0] C_RD_BASE     = ADDR_WIDTH'(RD_BASE);

   // Free space >= BURST_LEN is rewritten as fill <= DEPTH - BURST_LEN,
   // which avoids a signed subtraction when the fill count is out of range.
   localparam logic [CNT_WIDTH:0]    C_BURST_LEN   = (CNT_WIDTH+1)'(BURST_LEN);
   localparam logic [CNT_WIDTH:0]    C_RD_MAX_FILL = (CNT_WIDTH+1)'(FIFO_DEPTH - BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_WAIT,
      S_RD_REQ,
      S_RD_WAIT
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_last_wr;
   logic                  w_last_wr_next;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
   logic                  r_wr_pend;
   logic                  w_wr_pend_next;
   logic                  r_rd_pend;
   logic                  w_rd_pend_next;
   logic                  r_wr_wrap;
   logic                  w_wr_wrap_next;
   logic                  r_rd_wrap;
   logic                  w_rd_wrap_next;
   logic                  r_wr_req;
   logic                  r_rd_req;
   logic                  r_busy;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [ADDR_WIDTH:0]   w_wr_sum;
   logic [ADDR_WIDTH:0]   w_rd_sum;
   logic                  w_wr_finish;
   logic                  w_rd_finish;

   assign w_wr_ok  = init_calib_complete && ({1'b0, wr_fifo_cnt} >= C_BURST_LEN);
   assign w_rd_ok  = init_calib_complete && rd_enable && ({1'b0, rd_fifo_cnt} <= C_RD_MAX_FILL);

   assign w_wr_sum = {1'b0, r_wr_ptr} + C_BURST_BYTES;
   assign w_rd_sum = {1'b0, r_rd_ptr} + C_BURST_BYTES;

   always_comb begin
      w_state_next   = r_state;
      w_last_wr_next = r_last_wr;
      w_wr_ptr_next  = r_wr_ptr;
      w_rd_ptr_next  = r_rd_ptr;
      // A clear pulse is remembered until the arbiter can apply it safely.
      w_wr_pend_next = r_wr_pend | wr_addr_clr;
      w_rd_pend_next = r_rd_pend | rd_addr_clr;
      w_wr_wrap_next = 1'b0;
      w_rd_wrap_next = 1'b0;
      w_wr_finish    = 1'b0;
      w_rd_finish    = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Pending clears take effect before arbitration so a burst
            // granted in this same cycle already starts at the base.
            if (r_wr_pend) begin
               w_wr_ptr_next  = C_WR_BASE;
               w_wr_pend_next = wr_addr_clr;
            end
            if (r_rd_pend) begin
               w_rd_ptr_next  = C_RD_BASE;
               w_rd_pend_next = rd_addr_clr;
            end
            // Write wins unless read is also eligible and write went last.
            if (w_wr_ok && (!w_rd_ok || !r_last_wr)) begin
               w_state_next   = S_WR_REQ;
               w_last_wr_next = 1'b1;
            end else if (w_rd_ok) begin
               w_state_next   = S_RD_REQ;
               w_last_wr_next = 1'b0;
            end
         end
         S_WR_REQ: begin
            if (wr_burst_ack) begin
               // ack+done together behaves as ack followed by done.
               if (wr_burst_done) w_wr_finish  = 1'b1;
               else               w_state_next = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (wr_burst_done) w_wr_finish = 1'b1;
         end
         S_RD_REQ: begin
            if (rd_burst_ack) begin
               if (rd_burst_done) w_rd_finish  = 1'b1;
               else               w_state_next = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (rd_burst_done) w_rd_finish = 1'b1;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Burst completion: a deferred clear overrides the advance and
      // suppresses the wrap pulse.
      if (w_wr_finish) begin
         w_state_next = S_IDLE;
         if (r_wr_pend) begin
            w_wr_ptr_next  = C_WR_BASE;
            w_wr_pend_next = wr_addr_clr;
         end else if (w_wr_sum < C_WR_END) begin
            w_wr_ptr_next  = w_wr_sum[ADDR_WIDTH-1:0];
         end else begin
            w_wr_ptr_next  = C_WR_BASE;
            w_wr_wrap_next = 1'b1;
         end
      end
      if (w_rd_finish) begin
         w_state_next = S_IDLE;
         if (r_rd_pend) begin
            w_rd_ptr_next  = C_RD_BASE;
            w_rd_pend_next = rd_addr_clr;
         end else if (w_rd_sum < C_RD_END) begin
            w_rd_ptr_next  = w_rd_sum[ADDR_WIDTH-1:0];
         end else begin
            w_rd_ptr_next  = C_RD_BASE;
            w_rd_wrap_next = 1'b1;
         end
      end
   end

   // Outputs are registered from the next-state value so req/busy line up
   // with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_last_wr <= 1'b0;
         r_wr_ptr  <= C_WR_BASE;
         r_rd_ptr  <= C_RD_BASE;
         r_wr_pend <= 1'b0;
         r_rd_pend <= 1'b0;
         r_wr_wrap <= 1'b0;
         r_rd_wrap <= 1'b0;
         r_wr_req  <= 1'b0;
         r_rd_req  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_last_wr <= w_last_wr_next;
         r_wr_ptr  <= w_wr_ptr_next;
         r_rd_ptr  <= w_rd_ptr_next;
         r_wr_pend <= w_wr_pend_next;
         r_rd_pend <= w_rd_pend_next;
         r_wr_wrap <= w_wr_wrap_next;
         r_rd_wrap <= w_rd_wrap_next;
         r_wr_req  <= (w_state_next == S_WR_REQ);
         r_rd_req  <= (w_state_next == S_RD_REQ);
         r_busy    <= (w_state_next != S_IDLE);
      end
   end

   assign wr_burst_req  = r_wr_req;
   assign rd_burst_req  = r_rd_req;
   assign wr_burst_addr = r_wr_ptr;
   assign rd_burst_addr = r_rd_ptr;
   assign wr_wrap       = r_wr_wrap;
   assign rd_wrap       = r_rd_wrap;
   assign busy          = r_busy;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_arbiter
//
// Scoreboard bench. The stimulus process sets FIFO levels, plays the AXI
// master (ack/done with random latency) and pushes expected events (grant
// direction/address, then end-of-burst pointer values and wrap pulses) into
// a queue computed by a small reference model of the arbitration rules.
// A monitor on the falling clock edge pops and compares whenever the DUT
// raises a request or drops busy.
// ---------------------------------------------------------------------------
module tb_ddr_burst_arbiter;

   localparam int AW     = 30;
   localparam int CW     = 10;
   localparam int BLEN   = 64;
   localparam int BBYTES = 1024;
   localparam int DEPTH  = 512;
   localparam int REGION = 4096;

   logic          clk = 1'b0;
   logic          reset;
   logic          init_calib_complete;
   logic [CW-1:0] wr_fifo_cnt;
   logic [CW-1:0] rd_fifo_cnt;
   logic          rd_enable;
   logic          wr_addr_clr;
   logic          rd_addr_clr;
   logic          wr_burst_req;
   logic [AW-1:0] wr_burst_addr;
   logic          wr_burst_ack;
   logic          wr_burst_done;
   logic          rd_burst_req;
   logic [AW-1:0] rd_burst_addr;
   logic          rd_burst_ack;
   logic          rd_burst_done;
   logic          wr_wrap;
   logic          rd_wrap;
   logic          busy;

   always #5 clk = ~clk;

   ddr_burst_arbiter dut (
      .clk                 (clk),
      .reset               (reset),
      .init_calib_complete (init_calib_complete),
      .wr_fifo_cnt         (wr_fifo_cnt),
      .rd_fifo_cnt         (rd_fifo_cnt),
      .rd_enable           (rd_enable),
      .wr_addr_clr         (wr_addr_clr),
      .rd_addr_clr         (rd_addr_clr),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_ack        (wr_burst_ack),
      .wr_burst_done       (wr_burst_done),
      .rd_burst_req        (rd_burst_req),
      .rd_burst_addr       (rd_burst_addr),
      .rd_burst_ack        (rd_burst_ack),
      .rd_burst_done       (rd_burst_done),
      .wr_wrap             (wr_wrap),
      .rd_wrap             (rd_wrap),
      .busy                (busy)
   );

   // kind 0 = grant expected, kind 1 = end of burst expected
   typedef struct {
      int            kind;
      bit            is_wr;
      logic [AW-1:0] wr_addr;
      logic [AW-1:0] rd_addr;
      bit            wr_wrap;
      bit            rd_wrap;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   int m_wr_ptr  = 0;
   int m_rd_ptr  = 0;
   bit m_last_wr = 0;
   bit m_wr_pend = 0;
   bit m_rd_pend = 0;

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic check_req(input bit is_wr, input logic [AW-1:0] addr);
      exp_t e;
      checks++;
      $display("GRANT %s addr=0x%0h", is_wr ? "WR" : "RD", addr);
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_req: got %s req addr=0x%0h, required no request", is_wr ? "WR" : "RD", addr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != 0 || e.is_wr != is_wr ||
             addr != (is_wr ? e.wr_addr : e.rd_addr)) begin
            failures++;
            $display("FAIL grant: got kind=0 %s addr=0x%0h, required kind=%0d %s addr=0x%0h",
                     is_wr ? "WR" : "RD", addr, e.kind, e.is_wr ? "WR" : "RD",
                     e.is_wr ? e.wr_addr : e.rd_addr);
         end
      end
   endtask

   task automatic check_end();
      exp_t e;
      checks++;
      $display("END   wr_addr=0x%0h rd_addr=0x%0h wr_wrap=%0b rd_wrap=%0b",
               wr_burst_addr, rd_burst_addr, wr_wrap, rd_wrap);
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_end: busy fell with no burst outstanding");
      end else begin
         e = exp_q.pop_front();
         if (e.kind != 1 || wr_burst_addr != e.wr_addr || rd_burst_addr != e.rd_addr ||
             wr_wrap != e.wr_wrap || rd_wrap != e.rd_wrap) begin
            failures++;
            $display("FAIL burst_end: got wr=0x%0h rd=0x%0h wrw=%0b rdw=%0b, required kind=%0d wr=0x%0h rd=0x%0h wrw=%0b rdw=%0b (got kind=1)",
                     wr_burst_addr, rd_burst_addr, wr_wrap, rd_wrap,
                     e.kind, e.wr_addr, e.rd_addr, e.wr_wrap, e.rd_wrap);
         end
      end
   endtask

   // Monitor
   logic prev_wr_req = 1'b0;
   logic prev_rd_req = 1'b0;
   logic prev_busy   = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         prev_wr_req = 1'b0;
         prev_rd_req = 1'b0;
         prev_busy   = 1'b0;
      end else begin
         if (wr_burst_req && !prev_wr_req) check_req(1'b1, wr_burst_addr);
         if (rd_burst_req && !prev_rd_req) check_req(1'b0, rd_burst_addr);
         if (prev_busy && !busy) begin
            check_end();
         end else begin
            checks++;
            if (wr_wrap || rd_wrap) begin
               failures++;
               $display("FAIL stray_wrap: got wr_wrap=%0b rd_wrap=%0b, required 0 0", wr_wrap, rd_wrap);
            end
         end
         prev_wr_req = wr_burst_req;
         prev_rd_req = rd_burst_req;
         prev_busy   = busy;
      end
   end

   // Model: pointer update at the end of a burst, pushed as an expectation.
   task automatic model_end(input bit is_wr);
      exp_t e;
      int   n;
      e.kind    = 1;
      e.is_wr   = is_wr;
      e.wr_wrap = 0;
      e.rd_wrap = 0;
      if (is_wr) begin
         if (m_wr_pend) begin
            m_wr_ptr  = 0;
            m_wr_pend = 0;
         end else begin
            n = m_wr_ptr + BBYTES;
            if (n < REGION) m_wr_ptr = n;
            else begin m_wr_ptr = 0; e.wr_wrap = 1; end
         end
      end else begin
         if (m_rd_pend) begin
            m_rd_ptr  = 0;
            m_rd_pend = 0;
         end else begin
            n = m_rd_ptr + BBYTES;
            if (n < REGION) m_rd_ptr = n;
            else begin m_rd_ptr = 0; e.rd_wrap = 1; end
         end
      end
      e.wr_addr = AW'(m_wr_ptr);
      e.rd_addr = AW'(m_rd_ptr);
      exp_q.push_back(e);
   endtask

   // One arbitration opportunity. Called at a falling edge with the DUT idle.
   // clr_mode: 0 random clear during the burst, 1 forced clear, 2 no clear.
   task automatic run_iter(input bit c, input int wc, input int rc, input bit re, input int clr_mode);
      bit   wok, rok, gw, simul, do_clr;
      int   n;
      exp_t e;
      init_calib_complete = c;
      wr_fifo_cnt         = CW'(wc);
      rd_fifo_cnt         = CW'(rc);
      rd_enable           = re;
      wok = c && (wc >= BLEN);
      rok = c && re && ((DEPTH - rc) >= BLEN);
      if (!wok && !rok) begin
         // No grant: acks/dones are ignored here, and clears apply at once.
         for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
               wr_burst_ack  = 1'($urandom_range(0, 1));
               wr_burst_done = 1'($urandom_range(0, 1));
               rd_burst_ack  = 1'($urandom_range(0, 1));
               rd_burst_done = 1'($urandom_range(0, 1));
               if (clr_mode == 0 && $urandom_range(0, 3) == 0) begin
                  wr_addr_clr = 1'b1;
                  m_wr_ptr    = 0;
               end
               if (clr_mode == 0 && $urandom_range(0, 3) == 0) begin
                  rd_addr_clr = 1'b1;
                  m_rd_ptr    = 0;
               end
            end else begin
               wr_burst_ack = 0; wr_burst_done = 0; rd_burst_ack = 0; rd_burst_done = 0;
               wr_addr_clr  = 0; rd_addr_clr   = 0;
            end
            @(negedge clk);
         end
         wr_burst_ack = 0; wr_burst_done = 0; rd_burst_ack = 0; rd_burst_done = 0;
         wr_addr_clr  = 0; rd_addr_clr   = 0;
         return;
      end

      gw        = wok && (!rok || !m_last_wr);
      m_last_wr = gw;
      e.kind    = 0;
      e.is_wr   = gw;
      e.wr_addr = AW'(m_wr_ptr);
      e.rd_addr = AW'(m_rd_ptr);
      e.wr_wrap = 0;
      e.rd_wrap = 0;
      exp_q.push_back(e);

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(gw ? wr_burst_req : rd_burst_req) && n < 20);
      checks++;
      if (n != 1) begin
         failures++;
         $display("FAIL grant_latency: %s req after %0d cycles, required 1", gw ? "WR" : "RD", n);
         if (n >= 20) finish_tb();
      end

      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_clr = (clr_mode == 1) || (clr_mode == 0 && $urandom_range(0, 2) == 0);
      simul  = !do_clr && ($urandom_range(0, 3) == 0);
      if (gw) wr_burst_ack = 1'b1; else rd_burst_ack = 1'b1;
      if (simul) begin
         model_end(gw);
         if (gw) wr_burst_done = 1'b1; else rd_burst_done = 1'b1;
         @(negedge clk);
         wr_burst_ack = 0; rd_burst_ack = 0; wr_burst_done = 0; rd_burst_done = 0;
         return;
      end
      @(negedge clk);
      wr_burst_ack = 0;
      rd_burst_ack = 0;
      checks++;
      if (wr_burst_req || rd_burst_req || !busy) begin
         failures++;
         $display("FAIL req_after_ack: got wr_req=%0b rd_req=%0b busy=%0b, required 0 0 1",
                  wr_burst_req, rd_burst_req, busy);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (do_clr) begin
         if (gw) begin wr_addr_clr = 1'b1; m_wr_pend = 1; end
         else    begin rd_addr_clr = 1'b1; m_rd_pend = 1; end
         @(negedge clk);
         wr_addr_clr = 0;
         rd_addr_clr = 0;
         @(negedge clk);
      end
      if ($urandom_range(0, 4) == 0) init_calib_complete = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_end(gw);
      if (gw) wr_burst_done = 1'b1; else rd_burst_done = 1'b1;
      @(negedge clk);
      wr_burst_done = 0;
      rd_burst_done = 0;
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_tb();
   end

   initial begin
      int cnt;
      int wc, rc;
      bit c, re;

      reset = 1'b1;
      init_calib_complete = 0; wr_fifo_cnt = 0; rd_fifo_cnt = 0; rd_enable = 0;
      wr_addr_clr = 0; rd_addr_clr = 0;
      wr_burst_ack = 0; wr_burst_done = 0; rd_burst_ack = 0; rd_burst_done = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_burst_req || rd_burst_req || busy || wr_wrap || rd_wrap ||
          wr_burst_addr != '0 || rd_burst_addr != '0) begin
         failures++;
         $display("FAIL reset_state: got req=%0b/%0b busy=%0b wrap=%0b/%0b addr=0x%0h/0x%0h, required all 0",
                  wr_burst_req, rd_burst_req, busy, wr_wrap, rd_wrap, wr_burst_addr, rd_burst_addr);
      end
      wr_fifo_cnt = CW'(100);
      reset = 1'b0;

      // Calibration gate
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_burst_req || rd_burst_req || busy) cnt++;
      end
      checks++;
      if (cnt != 0) begin
         failures++;
         $display("FAIL calib_gate: got %0d active cycles, required 0", cnt);
      end
      run_iter(1, 100, 0, 0, 2);

      // Write sequence through the wrap
      for (int i = 0; i < 4; i++) run_iter(1, 64, 0, 0, 2);
      // Round-robin on ties
      for (int i = 0; i < 4; i++) run_iter(1, 64, 0, 1, 2);
      // Read back-pressure and read enable
      run_iter(1, 0, 449, 1, 2);
      run_iter(1, 0, 448, 1, 2);
      run_iter(1, 0, 0, 0, 2);
      // Deferred clear on the write side
      run_iter(1, 64, 0, 0, 1);
      run_iter(1, 64, 0, 0, 2);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         wc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 1023));
         rc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(444, 452)) : int'($urandom_range(0, 1023));
         re = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 7) != 0);
         run_iter(c, wc, rc, re, 0);
      end

      // Reset in the middle of a read burst
      run_iter(1, 0, 0, 1, 2);
      init_calib_complete = 1; wr_fifo_cnt = 0; rd_fifo_cnt = 0; rd_enable = 1;
      begin
         exp_t e;
         e.kind = 0; e.is_wr = 0; e.wr_addr = AW'(m_wr_ptr); e.rd_addr = AW'(m_rd_ptr);
         e.wr_wrap = 0; e.rd_wrap = 0;
         exp_q.push_back(e);
         m_last_wr = 0;
      end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!rd_burst_req && cnt < 20);
      checks++;
      if (!rd_burst_req) begin
         failures++;
         $display("FAIL reset_setup: rd_req not seen, required 1");
         finish_tb();
      end
      rd_burst_ack = 1'b1;
      @(negedge clk);
      rd_burst_ack = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (wr_burst_req || rd_burst_req || busy || wr_burst_addr != '0 || rd_burst_addr != '0) begin
         failures++;
         $display("FAIL reset_midburst: got req=%0b/%0b busy=%0b addr=0x%0h/0x%0h, required 0 0 0 0x0 0x0",
                  wr_burst_req, rd_burst_req, busy, wr_burst_addr, rd_burst_addr);
      end
      m_wr_ptr = 0; m_rd_ptr = 0; m_last_wr = 0; m_wr_pend = 0; m_rd_pend = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_iter(1, 64, 0, 1, 2);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
      end
      finish_tb();
   end

endmodule
